// File: rtl/conv_pkg.sv
// Shared sizing helpers and output saturation for the streaming convolution engine.
// Latency: none (compile-time and combinational helpers only).
// Backpressure: not applicable.
package conv_pkg;

   localparam int SAT_W = 64;

   // Number of valid window positions along one axis (no padding).
   function automatic int out_dim(input int data, input int filt, input int stride);
      return (data - filt) / stride + 1;
   endfunction

   // Accumulator width: full product width plus growth for the tap count plus bias headroom.
   function automatic int acc_width(input int bw, input int taps);
      return 2 * bw + $clog2(taps) + 1;
   endfunction

   // Clamp a wide signed value to the range of a signed 'width'-bit word.
   function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] val,
                                                          input int width);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (width - 1));
      if (val > hi) return hi;
      if (val < lo) return lo;
      return val;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// Delay line returning the word written DEPTH enabled cycles earlier (one frame line).
// Latency: DEPTH enables from din to dout; dout is a combinational read.
// Backpressure: holds completely while en is low.
module line_buffer #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 28
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    ptr_q;
   logic [PW-1:0]    ptr_d;

   // The slot about to be overwritten holds the oldest word, i.e. the pixel one line back.
   assign dout = mem_q[ptr_q];

   // Circular pointer advance.
   always_comb begin
      ptr_d = ptr_q;
      if (en) ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
   end

   // Pointer register; reset only so simulation starts from a known slot.
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   // Storage write; contents are refilled before use so they are never reset.
   always_ff @(posedge clk) begin
      if (en) mem_q[ptr_q] <= din;
   end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming 2-D convolution: raster pixels in, one saturated word per valid window out.
// Latency: 2 cycles from the accepted firing pixel to out_valid.
// Backpressure: a single global advance stalls counters, line buffers, window and both MAC stages.
module conv2d_stream
   import conv_pkg::*;
#(
   parameter int BITWIDTH     = 8,
   parameter int DATAWIDTH    = 28,
   parameter int DATAHEIGHT   = 28,
   parameter int DATACHANNEL  = 3,
   parameter int FILTERHEIGHT = 5,
   parameter int FILTERWIDTH  = 5,
   parameter int FILTERBATCH  = 1,
   parameter int STRIDEHEIGHT = 1,
   parameter int STRIDEWIDTH  = 1
) (
   input  logic                                                             clk,
   input  logic                                                             rst,
   input  logic                                                             in_valid,
   output logic                                                             in_ready,
   input  logic [BITWIDTH*DATACHANNEL-1:0]                                  in_data,
   input  logic [BITWIDTH*FILTERHEIGHT*FILTERWIDTH*DATACHANNEL*FILTERBATCH-1:0] filterWeight,
   input  logic [BITWIDTH*FILTERBATCH-1:0]                                  filterBias,
   output logic                                                             out_valid,
   input  logic                                                             out_ready,
   output logic [2*BITWIDTH*FILTERBATCH-1:0]                                out_data,
   output logic                                                             out_last
);
   localparam int PIXW  = BITWIDTH * DATACHANNEL;
   localparam int OUTW  = 2 * BITWIDTH;
   localparam int TAPS  = FILTERHEIGHT * FILTERWIDTH * DATACHANNEL;
   localparam int NPROD = TAPS * FILTERBATCH;
   localparam int ACCW  = acc_width(BITWIDTH, TAPS);
   localparam int OW    = out_dim(DATAWIDTH, FILTERWIDTH, STRIDEWIDTH);
   localparam int OH    = out_dim(DATAHEIGHT, FILTERHEIGHT, STRIDEHEIGHT);
   localparam int CW    = $clog2(DATAWIDTH + 1);
   localparam int RW    = $clog2(DATAHEIGHT + 1);
   localparam int LBN   = (FILTERHEIGHT > 1) ? FILTERHEIGHT - 1 : 1;

   logic advance;
   logic accept;
   logic fire;
   logic fire_last;

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   logic [PIXW-1:0] lb_tap  [LBN];
   logic [PIXW-1:0] new_col [FILTERHEIGHT];
   logic [PIXW-1:0] win_q   [FILTERHEIGHT][FILTERWIDTH];
   logic [PIXW-1:0] win_d   [FILTERHEIGHT][FILTERWIDTH];

   logic signed [OUTW-1:0] prod_q [NPROD];
   logic signed [OUTW-1:0] prod_d [NPROD];
   logic s1_vld_q, s1_vld_d;
   logic s1_last_q, s1_last_d;

   logic                        out_valid_q, out_valid_d;
   logic                        out_last_q,  out_last_d;
   logic [OUTW*FILTERBATCH-1:0] out_data_q,  out_data_d;

   assign advance   = !out_valid_q || out_ready;
   assign in_ready  = advance;
   assign accept    = in_valid && advance;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;

   // Raster position of the pixel currently offered; wraps per line and per frame.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (accept) begin
         if (col_q == CW'(DATAWIDTH - 1)) begin
            col_d = '0;
            row_d = (row_q == RW'(DATAHEIGHT - 1)) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Window fires when the offered pixel closes a strided, fully in-frame window.
   always_comb begin
      int ri;
      int ci;
      ri        = int'(row_q) - (FILTERHEIGHT - 1);
      ci        = int'(col_q) - (FILTERWIDTH - 1);
      fire      = (ri >= 0) && (ci >= 0) &&
                  ((ri % STRIDEHEIGHT) == 0) && ((ci % STRIDEWIDTH) == 0) &&
                  ((ri / STRIDEHEIGHT) < OH) && ((ci / STRIDEWIDTH) < OW);
      fire_last = fire && ((ri / STRIDEHEIGHT) == OH - 1) && ((ci / STRIDEWIDTH) == OW - 1);
   end

   // Line buffers chained so buffer i yields the pixel i+1 rows above the current one.
   for (genvar i = 0; i < FILTERHEIGHT - 1; i++) begin : g_lb
      logic [PIXW-1:0] lb_din;
      if (i == 0) begin : g_first
         assign lb_din = in_data;
      end else begin : g_next
         assign lb_din = lb_tap[i-1];
      end
      line_buffer #(.WIDTH(PIXW), .DEPTH(DATAWIDTH)) u_lb (
         .clk  (clk),
         .rst  (rst),
         .en   (accept),
         .din  (lb_din),
         .dout (lb_tap[i])
      );
   end

   // Incoming window column: bottom row is the live pixel, upper rows come from the buffers.
   for (genvar r = 0; r < FILTERHEIGHT; r++) begin : g_col
      if (r == FILTERHEIGHT - 1) begin : g_live
         assign new_col[r] = in_data;
      end else begin : g_tap
         assign new_col[r] = lb_tap[FILTERHEIGHT-2-r];
      end
   end

   // Window slides left on every accepted pixel, taking the new column on the right.
   always_comb begin
      win_d = win_q;
      if (accept) begin
         for (int r = 0; r < FILTERHEIGHT; r++) begin
            for (int s = 0; s < FILTERWIDTH - 1; s++) win_d[r][s] = win_q[r][s+1];
            win_d[r][FILTERWIDTH-1] = new_col[r];
         end
      end
   end

   // Stage-1 products use the post-shift window so the firing pixel is already included.
   always_comb begin
      int k;
      for (int f = 0; f < FILTERBATCH; f++) begin
         for (int c = 0; c < DATACHANNEL; c++) begin
            for (int r = 0; r < FILTERHEIGHT; r++) begin
               for (int s = 0; s < FILTERWIDTH; s++) begin
                  k = ((f * DATACHANNEL + c) * FILTERHEIGHT + r) * FILTERWIDTH + s;
                  prod_d[k] = OUTW'($signed(win_d[r][s][c*BITWIDTH +: BITWIDTH])) *
                              OUTW'($signed(filterWeight[k*BITWIDTH +: BITWIDTH]));
               end
            end
         end
      end
      s1_vld_d  = advance ? (accept && fire)      : s1_vld_q;
      s1_last_d = advance ? (accept && fire_last) : s1_last_q;
   end

   // Stage 2: per-filter sum plus bias, clamped to the output word; holds under stall.
   always_comb begin
      logic signed [ACCW-1:0] acc;
      acc         = '0;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      if (advance) begin
         out_valid_d = s1_vld_q;
         out_last_d  = s1_last_q;
         for (int f = 0; f < FILTERBATCH; f++) begin
            acc = ACCW'($signed(filterBias[f*BITWIDTH +: BITWIDTH]));
            for (int t = 0; t < TAPS; t++) acc = acc + ACCW'(prod_q[f*TAPS + t]);
            out_data_d[f*OUTW +: OUTW] = OUTW'(sat_signed(64'(acc), OUTW));
         end
      end
   end

   // Control state: counters, pipeline valids and the output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= '0;
         s1_vld_q    <= 1'b0;
         s1_last_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         s1_vld_q    <= s1_vld_d;
         s1_last_q   <= s1_last_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   // Datapath registers; every window is refilled before it fires, so no reset is needed.
   always_ff @(posedge clk) begin
      win_q  <= win_d;
      prod_q <= prod_d;
   end

endmodule

// File: tb/tb_conv2d_stream.sv
// Self-checking bench: golden convolution model feeding a scoreboard queue.
// Latency: checks the 2-cycle pixel-to-output delay when no stall is present.
// Backpressure: random and forced out_ready stalls with output hold checks.
module tb_conv2d_stream;
   localparam int BW = 8, DW = 6, DH = 6, DC = 2, FH = 3, FW = 3, FB = 2, SH = 2, SW = 2;
   localparam int OWD  = (DW - FW) / SW + 1;
   localparam int OHD  = (DH - FH) / SH + 1;
   localparam int OUTW = 2 * BW;

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, out_valid, out_ready, out_last;
   logic [BW*DC-1:0]          in_data;
   logic [BW*FH*FW*DC*FB-1:0] filterWeight;
   logic [BW*FB-1:0]          filterBias;
   logic [OUTW*FB-1:0]        out_data;

   always #5 clk = ~clk;

   conv2d_stream #(
      .BITWIDTH(BW), .DATAWIDTH(DW), .DATAHEIGHT(DH), .DATACHANNEL(DC),
      .FILTERHEIGHT(FH), .FILTERWIDTH(FW), .FILTERBATCH(FB),
      .STRIDEHEIGHT(SH), .STRIDEWIDTH(SW)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .filterWeight(filterWeight), .filterBias(filterBias),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   typedef struct {
      logic [OUTW*FB-1:0] dat;
      logic               last;
      int                 t_acc;
   } exp_t;

   int   pix  [DH][DW][DC];
   int   wgt  [FB][DC][FH][FW];
   int   bias [FB];
   exp_t sb   [$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   bit strict_lat = 1'b0;
   bit hold_pend = 1'b0;
   logic [OUTW*FB-1:0] hold_dat;
   logic               hold_last;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [OUTW*FB-1:0] golden(input int orow, input int ocol);
      logic [OUTW*FB-1:0] v;
      v = '0;
      for (int f = 0; f < FB; f++) begin
         int acc;
         acc = bias[f];
         for (int c = 0; c < DC; c++)
            for (int r = 0; r < FH; r++)
               for (int s = 0; s < FW; s++)
                  acc += pix[orow*SH + r][ocol*SW + s][c] * wgt[f][c][r][s];
         if (acc > 32767)  acc = 32767;
         if (acc < -32768) acc = -32768;
         v[f*OUTW +: OUTW] = OUTW'(acc);
      end
      return v;
   endfunction

   task automatic load_params();
      for (int f = 0; f < FB; f++) begin
         for (int c = 0; c < DC; c++)
            for (int r = 0; r < FH; r++)
               for (int s = 0; s < FW; s++)
                  filterWeight[(((f*DC + c)*FH + r)*FW + s)*BW +: BW] = BW'(wgt[f][c][r][s]);
         filterBias[f*BW +: BW] = BW'(bias[f]);
      end
   endtask

   task automatic set_wgt(input int w0, input int w1, input bit centre_only, input int b);
      for (int f = 0; f < FB; f++) begin
         for (int c = 0; c < DC; c++)
            for (int r = 0; r < FH; r++)
               for (int s = 0; s < FW; s++)
                  wgt[f][c][r][s] = (centre_only && !(r == 1 && s == 1)) ? 0 : ((f == 0) ? w0 : w1);
         bias[f] = b;
      end
      load_params();
   endtask

   task automatic rand_wgt();
      for (int f = 0; f < FB; f++) begin
         for (int c = 0; c < DC; c++)
            for (int r = 0; r < FH; r++)
               for (int s = 0; s < FW; s++) wgt[f][c][r][s] = int'($urandom_range(0, 255)) - 128;
         bias[f] = int'($urandom_range(0, 255)) - 128;
      end
      load_params();
   endtask

   // mode 0: constant v, mode 1: row*DW+col ramp, mode 2: random
   task automatic fill_pix(input int mode, input int v);
      for (int r = 0; r < DH; r++)
         for (int c = 0; c < DW; c++)
            for (int ch = 0; ch < DC; ch++)
               pix[r][c][ch] = (mode == 0) ? v :
                               (mode == 1) ? r*DW + c : int'($urandom_range(0, 255)) - 128;
   endtask

   // One bench cycle: drive at negedge, observe just after, score outputs transferred this cycle.
   task automatic step(input logic iv, input logic [BW*DC-1:0] d, input logic orr, output bit acc);
      exp_t e;
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      out_ready = orr;
      #1;
      cyc++;
      if (hold_pend) begin
         check("hold_dat", out_data, hold_dat);
         check("hold_last", 64'(out_last), 64'(hold_last));
      end
      hold_pend = out_valid && !out_ready;
      hold_dat  = out_data;
      hold_last = out_last;
      if (hold_pend) check("in_ready_stall", 64'(in_ready), 64'(0));
      if (out_valid && out_ready) begin
         check("sb_has_entry", 64'(sb.size() > 0), 64'(1));
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("out_dat", out_data, e.dat);
            check("out_last", 64'(out_last), 64'(e.last));
            if (strict_lat) check("latency", 64'(cyc - e.t_acc), 64'(2));
         end
      end
      acc = iv && in_ready;
   endtask

   task automatic send_pixel(input int row, input int col, input int vpct, input int rpct);
      bit   acc;
      int   tries;
      logic iv, orr;
      logic [BW*DC-1:0] d;
      exp_t e;
      int   ri, ci;
      for (int ch = 0; ch < DC; ch++) d[ch*BW +: BW] = BW'(pix[row][col][ch]);
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 200) begin
         iv  = ($urandom_range(0, 99) < vpct);
         orr = ($urandom_range(0, 99) < rpct);
         step(iv, d, orr, acc);
         tries++;
      end
      check("accept_in_budget", 64'(acc), 64'(1));
      ri = row - (FH - 1);
      ci = col - (FW - 1);
      if (acc && ri >= 0 && ci >= 0 && ri % SH == 0 && ci % SW == 0 &&
          ri / SH < OHD && ci / SW < OWD) begin
         e.dat   = golden(ri / SH, ci / SW);
         e.last  = (ri / SH == OHD - 1) && (ci / SW == OWD - 1);
         e.t_acc = cyc;
         sb.push_back(e);
      end
   endtask

   task automatic send_frame(input int vpct, input int rpct, input int stall_at, input int npix);
      bit acc;
      for (int p = 0; p < npix; p++) begin
         if (p == stall_at)
            for (int k = 0; k < 5; k++) step(1'b0, '0, 1'b0, acc);
         send_pixel(p / DW, p % DW, vpct, rpct);
      end
   endtask

   task automatic drain();
      bit acc;
      int n;
      n = 0;
      while (sb.size() > 0 && n < 100) begin
         step(1'b0, '0, 1'b1, acc);
         n++;
      end
      check("drain_empty", 64'(sb.size()), 64'(0));
      step(1'b0, '0, 1'b1, acc);
      check("idle_no_valid", 64'(out_valid), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      filterWeight = '0; filterBias = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_last", 64'(out_last), 64'(0));
      check("rst_out_data", out_data, 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      rst = 1'b0;

      // All ones with bias 2: each filter gives 18 + 2; exact 2-cycle latency.
      fill_pix(0, 1);
      set_wgt(1, 1, 1'b0, 2);
      strict_lat = 1'b1;
      send_frame(100, 100, -1, DW*DH);
      drain();

      // Ramp pixels, unit-centre weights, filter 1 negated: outputs +/-2x centre pixel.
      fill_pix(1, 0);
      set_wgt(1, -1, 1'b1, 0);
      send_frame(100, 100, -1, DW*DH);
      drain();
      strict_lat = 1'b0;

      // Positive then negative saturation.
      fill_pix(0, 127);
      set_wgt(127, 127, 1'b0, 0);
      send_frame(100, 100, -1, DW*DH);
      drain();
      set_wgt(-128, -128, 1'b0, 0);
      send_frame(100, 100, -1, DW*DH);
      drain();

      // Forced 5-cycle out_ready stall right after the first window output.
      rand_wgt();
      fill_pix(2, 0);
      send_frame(100, 100, 2*DW + 4, DW*DH);
      drain();

      // Reset after 7 pixels, then a clean full frame.
      fill_pix(2, 0);
      send_frame(100, 100, -1, 7);
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'(0));
      check("midrst_in_ready", 64'(in_ready), 64'(1));
      sb.delete();
      hold_pend = 1'b0;
      fill_pix(2, 0);
      send_frame(100, 100, -1, DW*DH);
      drain();

      // Back-to-back frames with random output stalls, then with random input gaps too.
      rand_wgt();
      for (int fr = 0; fr < 2; fr++) begin
         fill_pix(2, 0);
         send_frame(100, 60, -1, DW*DH);
      end
      drain();
      for (int fr = 0; fr < 2; fr++) begin
         fill_pix(2, 0);
         send_frame(70, 70, -1, DW*DH);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
